// File: rtl/tx_frame_sched.sv
// tx_frame_sched: round-robin scheduler sharing one UART TX byte port between
// several frame sources. Each granted source is walked byte by byte into the
// TX FIFO under tx_full backpressure.
// Optional feature macro: TX_FRAME_SCHED_ABORT_EN (dropping the granted req
// mid-frame truncates the frame and finishes it with a done pulse).
module tx_frame_sched #(
    parameter int NUM_REQ  = 3,
    parameter int DBITS    = 8,
    parameter int LEN_BITS = 6,
    parameter int MAX_LEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*LEN_BITS-1:0]  req_len,
    output logic [NUM_REQ-1:0]           grant,
    output logic [LEN_BITS-1:0]          rd_idx,
    input  logic [DBITS-1:0]             rd_data,
    output logic [DBITS-1:0]             tx_data,
    output logic                         tx_wr,
    input  logic                         tx_full,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [LEN_BITS-1:0] r_len;
    logic [LEN_BITS-1:0] r_rd_idx;
    logic [IDX_W-1:0]    r_last;

    logic                w_found;
    logic [IDX_W-1:0]    w_pick;
    int                  w_cand;
    logic [LEN_BITS-1:0] w_pick_len;
    logic [LEN_BITS-1:0] w_len;
    logic [NUM_REQ-1:0]  w_onehot;
    logic                w_abort;
    logic                w_write;

    // Round-robin search: first set req bit starting just after the last served source.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req[IDX_W'(w_cand)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_cand);
            end
        end
    end

    assign w_pick_len = req_len[int'(w_pick)*LEN_BITS +: LEN_BITS];
    assign w_len      = (w_pick_len > LEN_BITS'(MAX_LEN)) ? LEN_BITS'(MAX_LEN) : w_pick_len;
    assign w_onehot   = NUM_REQ'(1) << w_pick;

`ifdef TX_FRAME_SCHED_ABORT_EN
    assign w_abort = (r_state == ST_SEND) && ((req & r_grant) == '0);
`else
    assign w_abort = 1'b0;
`endif

    assign w_write = (r_state == ST_SEND) && !tx_full && !w_abort;

    assign grant   = r_grant;
    assign rd_idx  = r_rd_idx;
    assign tx_wr   = w_write;
    assign tx_data = (r_state == ST_SEND) ? rd_data : '0;
    assign done    = (r_state == ST_DONE) ? r_grant : '0;
    assign busy    = (r_state != ST_IDLE);

    // Frame FSM: arbitrate in IDLE, stream bytes in SEND, pulse done in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_len    <= '0;
            r_rd_idx <= '0;
            r_last   <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_onehot;
                        r_last   <= w_pick;
                        r_rd_idx <= '0;
                        r_len    <= w_len;
                        r_state  <= (w_len != '0) ? ST_SEND : ST_DONE;
                    end
                end
                ST_SEND: begin
                    if (w_abort) begin
                        r_state <= ST_DONE;
                    end else if (w_write) begin
                        r_rd_idx <= r_rd_idx + LEN_BITS'(1);
                        if (r_rd_idx == r_len - LEN_BITS'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_grant  <= '0;
                    r_rd_idx <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Testbench for tx_frame_sched: a frame-level reference model predicts which
// source is served and how many bytes it sends; a monitor checks every write
// and done pulse against that prediction. Honours TX_FRAME_SCHED_ABORT_EN.
module tb_tx_frame_sched;

    localparam int NUM  = 3;
    localparam int LB   = 6;
    localparam int MAXL = 32;

    typedef struct {
        int src;
        int len;
    } frame_t;

    logic            clk;
    logic            reset;
    logic [NUM-1:0]  req;
    logic [NUM*LB-1:0] req_len;
    logic [NUM-1:0]  grant;
    logic [LB-1:0]   rd_idx;
    logic [7:0]      rdData;
    logic [7:0]      tx_data;
    logic            tx_wr;
    logic            tx_full;
    logic [NUM-1:0]  done;
    logic            busy;

    logic [7:0] dataMem [NUM][64];
    int         lenArr [NUM];
    frame_t     frameQ [$];
    int         modelLast;
    int         wrCnt;
    int         totalWrites;
    int         doneCount;
    int         checks;
    int         errors;
    bit         fullEn;

    tx_frame_sched #(
        .NUM_REQ (NUM),
        .DBITS   (8),
        .LEN_BITS(LB),
        .MAX_LEN (MAXL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .req_len(req_len),
        .grant  (grant),
        .rd_idx (rd_idx),
        .rd_data(rdData),
        .tx_data(tx_data),
        .tx_wr  (tx_wr),
        .tx_full(tx_full),
        .done   (done),
        .busy   (busy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each source answers combinationally with its stored byte at the requested index.
    always_comb begin
        rdData = '0;
        for (int i = 0; i < NUM; i++) begin
            if (grant[i]) rdData = dataMem[i][rd_idx];
        end
    end

    // Random FIFO-full backpressure, changed shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (fullEn) tx_full = ($urandom_range(0, 3) == 0);
        else        tx_full = 1'b0;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write and done pulse is matched to the oldest predicted frame.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_wr) begin
                checks++;
                if (frameQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedWrite: got write data %0d expected no write", tx_data);
                end else begin
                    checks--;
                    checkOutput("wrWhileFull", int'(tx_full), 0);
                    checkOutput("wrGrant", int'(grant), 1 << frameQ[0].src);
                    checkOutput("wrIdx", int'(rd_idx), wrCnt);
                    checkOutput("wrData", int'(tx_data), int'(dataMem[frameQ[0].src][wrCnt & 63]));
                    wrCnt++;
                    totalWrites++;
                end
            end
            if (done != '0) begin
                checks++;
                if (frameQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpectedDone: got done %0d expected none", done);
                end else begin
                    checks--;
                    checkOutput("doneSrc", int'(done), 1 << frameQ[0].src);
                    checkOutput("frameBytes", wrCnt, frameQ[0].len);
                    void'(frameQ.pop_front());
                    wrCnt = 0;
                    doneCount++;
                end
            end
        end
    end

    // Reference arbitration: next requesting source after the last served one.
    function automatic int pickNext(input logic [NUM-1:0] mask);
        for (int k = 1; k <= NUM; k++) begin
            if (mask[(modelLast + k) % NUM]) return (modelLast + k) % NUM;
        end
        return modelLast;
    endfunction

    function automatic int clampLen(input int l);
        return (l > MAXL) ? MAXL : l;
    endfunction

    task automatic packLens();
        for (int i = 0; i < NUM; i++) req_len[i*LB +: LB] = LB'(lenArr[i]);
    endtask

    task automatic waitDone(input int target);
        int cyc;
        cyc = 0;
        while (doneCount < target && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (doneCount < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: got %0d frames expected %0d", doneCount, target);
            frameQ.delete();
            wrCnt = 0;
            doneCount = target;
        end
    endtask

    task automatic settleIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleBusy", int'(busy), 0);
        checkOutput("idleGrant", int'(grant), 0);
        checkOutput("queueEmpty", frameQ.size(), 0);
    endtask

    // Holds mask for exactly 'frames' frames; the model predicts their order and lengths.
    task automatic applyStimulus(input logic [NUM-1:0] mask, input int frames);
        int s;
        int baseDone;
        for (int f = 0; f < frames; f++) begin
            frame_t fr;
            s = pickNext(mask);
            modelLast = s;
            fr.src = s;
            fr.len = clampLen(lenArr[s]);
            frameQ.push_back(fr);
        end
        packLens();
        baseDone = doneCount;
        req = mask;
        waitDone(baseDone + frames);
        req = '0;
        settleIdle();
    endtask

    task automatic randomData();
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < 64; j++) dataMem[i][j] = 8'($urandom);
    endtask

    // Waits, bounded, until the monitor has counted 'target' writes.
    task automatic waitWrites(input int target);
        int cyc;
        cyc = 0;
        while (totalWrites < target && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (totalWrites < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL writeTimeout: got %0d writes expected %0d", totalWrites, target);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_t fr;
        int base;
        int baseDone;
        checks = 0; errors = 0; wrCnt = 0; totalWrites = 0; doneCount = 0;
        modelLast = NUM - 1;
        fullEn = 1'b0;
        reset = 1'b1; req = '0; req_len = '0; tx_full = 1'b0;
        for (int i = 0; i < NUM; i++) lenArr[i] = 0;
        randomData();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstGrant", int'(grant), 0);
        checkOutput("rstIdx", int'(rd_idx), 0);
        checkOutput("rstWr", int'(tx_wr), 0);
        checkOutput("rstData", int'(tx_data), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstBusy", int'(busy), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single frame of "ABC" from source 0.
        dataMem[0][0] = 8'h41; dataMem[0][1] = 8'h42; dataMem[0][2] = 8'h43;
        lenArr[0] = 3;
        applyStimulus(3'b001, 1);

        // Round robin between sources 0 and 2.
        lenArr[0] = 1; lenArr[2] = 1;
        applyStimulus(3'b101, 4);

        // Backpressure on a 4-byte frame.
        fullEn = 1'b1;
        lenArr[0] = 4;
        applyStimulus(3'b001, 2);
        fullEn = 1'b0;

        // Length edges: empty frame and an over-long frame clamped to MAX_LEN.
        lenArr[1] = 0;
        applyStimulus(3'b010, 1);
        lenArr[1] = 50;
        applyStimulus(3'b010, 1);

        // Reset in the middle of a 5-byte frame.
        lenArr[0] = 5;
        packLens();
        fr.src = 0; fr.len = 5;
        frameQ.push_back(fr);
        base = totalWrites;
        baseDone = doneCount;
        req = 3'b001;
        waitWrites(base + 2);
        reset = 1'b1;
        req = '0;
        #1;
        checkOutput("midRstWr", int'(tx_wr), 0);
        checkOutput("midRstGrant", int'(grant), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        checkOutput("midRstDone", int'(done), 0);
        frameQ.delete();
        wrCnt = 0;
        modelLast = NUM - 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("midRstNoDone", doneCount, baseDone);
        checkOutput("midRstWrites", totalWrites, base + 2);
        lenArr[0] = 2; lenArr[2] = 2;
        applyStimulus(3'b101, 2);

        // Requester withdraws after 2 of 6 bytes.
        lenArr[0] = 6;
        packLens();
        fr.src = 0;
`ifdef TX_FRAME_SCHED_ABORT_EN
        fr.len = 2;
`else
        fr.len = 6;
`endif
        frameQ.push_back(fr);
        modelLast = 0;
        base = totalWrites;
        baseDone = doneCount;
        req = 3'b001;
        waitWrites(base + 2);
        req = '0;
        waitDone(baseDone + 1);
        settleIdle();

        // Randomized traffic with random backpressure.
        fullEn = 1'b1;
        for (int b = 0; b < 25; b++) begin
            logic [NUM-1:0] mask;
            randomData();
            for (int i = 0; i < NUM; i++) begin
                case ($urandom_range(0, 4))
                    0:       lenArr[i] = 0;
                    1:       lenArr[i] = $urandom_range(33, 63);
                    default: lenArr[i] = $urandom_range(1, 12);
                endcase
            end
            mask = NUM'($urandom_range(1, (1 << NUM) - 1));
            applyStimulus(mask, $urandom_range(1, 5));
        end
        fullEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
